shift_sequencer: RTL and testbench

Upstream issue stage for the 32-bit `barrel_shifter`. Accepts shift commands with an 8-bit shift amount over a valid/ready handshake, drives the shifter with one or two passes of at most 31 positions, and feeds each pass result back as the next pass operand. It then presents the final result on a valid/ready output. This extends the shifter's 5-bit amount range to 0..255 with correct saturating semantics, and handles shifter output latency through a parameter.

---
 rtl/shift_sequencer.sv | 129 ++++++++++++
 tb/tb_shift_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-pass issue stage extending a 5-bit barrel shifter to 8-bit amounts
//
// Purpose: accepts one shift command at a time, drives an external 32-bit
// barrel shifter with one or two passes of at most 31 positions, feeds each
// pass result back as the next operand, and presents the final result.
// Amounts of 32 or more saturate (two passes: 31 then 1).
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_valid / o_ready       command handshake
//   i_data, i_shift_amt     operand and 8-bit shift amount
//   i_shift_left, i_signed  direction and arithmetic-right flag
//   o_sh_data, o_sh_shift_amt, o_sh_shift_left, o_sh_signed   shifter drive
//   i_sh_data               shifter result, SH_LAT cycles after drive
//   o_valid / i_ready       result handshake
//   o_data                  final shifted result
module shift_sequencer #(
   parameter int SH_LAT = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [31:0] i_data,
   input  logic [7:0]  i_shift_amt,
   input  logic        i_shift_left,
   input  logic        i_signed,
   output logic [31:0] o_sh_data,
   output logic [4:0]  o_sh_shift_amt,
   output logic        o_sh_shift_left,
   output logic        o_sh_signed,
   input  logic [31:0] i_sh_data,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_data
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] LAT = 2'(SH_LAT);

   state_t      state_q, state_d;
   logic [31:0] op_q, op_d;
   logic [5:0]  rem_q, rem_d;
   logic [1:0]  wcnt_q, wcnt_d;
   logic        left_q, left_d;
   logic        signed_q, signed_d;
   logic [4:0]  pass_amt;

   // Each pass covers at most 31 positions; the remainder goes to the next pass.
   always_comb begin
      pass_amt = (rem_q >= 6'd31) ? 5'd31 : rem_q[4:0];
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      rem_d    = rem_q;
      wcnt_d   = wcnt_q;
      left_d   = left_q;
      signed_d = signed_q;
      case (state_q)
         IDLE: begin
            if (i_valid) begin
               state_d  = RUN;
               op_d     = i_data;
               left_d   = i_shift_left;
               signed_d = i_signed;
               // Clamping to 32 gives saturating results with exactly two passes.
               rem_d    = (i_shift_amt >= 8'd32) ? 6'd32 : i_shift_amt[5:0];
               wcnt_d   = 2'd0;
            end
         end
         RUN: begin
            if (wcnt_q == LAT) begin
               op_d   = i_sh_data;
               rem_d  = rem_q - {1'b0, pass_amt};
               wcnt_d = 2'd0;
               // A zero amount still takes one pass, so test the remainder after subtraction.
               if (rem_q == {1'b0, pass_amt}) begin
                  state_d = DONE;
               end
            end else begin
               wcnt_d = wcnt_q + 2'd1;
            end
         end
         DONE: begin
            if (i_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= IDLE;
         op_q     <= 32'h0;
         rem_q    <= 6'd0;
         wcnt_q   <= 2'd0;
         left_q   <= 1'b0;
         signed_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         rem_q    <= rem_d;
         wcnt_q   <= wcnt_d;
         left_q   <= left_d;
         signed_q <= signed_d;
      end
   end

   // o_ready is gated by reset so no command is accepted while reset is held.
   assign o_ready         = (state_q == IDLE) && !i_rst;
   assign o_valid         = (state_q == DONE);
   assign o_data          = op_q;
   assign o_sh_data       = op_q;
   assign o_sh_shift_amt  = (state_q == RUN) ? pass_amt : 5'd0;
   assign o_sh_shift_left = left_q;
   assign o_sh_signed     = signed_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - scoreboard bench for shift_sequencer over SH_LAT 0..3
module tb_shift_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  v_in, rdy_out, vo, rdy_in, left, sgn, sh_left, sh_sgn;
   logic [31:0] d_in [4];
   logic [31:0] sh_d_o [4];
   logic [31:0] sh_d_i [4];
   logic [31:0] d_out [4];
   logic [7:0]  amt [4];
   logic [4:0]  sh_amt [4];

   int          checks = 0;
   int          failures = 0;
   logic [31:0] sb_data [$];
   int          sb_lat [$];
   logic [4:0]  first_amt, last_amt;
   int          cyc;
   logic [31:0] hold_exp;
   logic        quiet;

   always #5 clk = ~clk;

   function automatic logic [31:0] golden(input logic [31:0] d, input logic [7:0] n,
                                          input logic l, input logic s);
      if (n >= 8'd32) return (!l && s) ? {32{d[31]}} : 32'h0;
      if (l) return d << n[4:0];
      if (s) return 32'($signed(d) >>> n[4:0]);
      return d >> n[4:0];
   endfunction

   for (genvar g = 0; g < 4; g++) begin : g_dut
      logic [31:0] comb_v, p1, p2, p3;
      shift_sequencer #(.SH_LAT(g)) u_dut (
         .i_clk           (clk),
         .i_rst           (rst),
         .i_valid         (v_in[g]),
         .o_ready         (rdy_out[g]),
         .i_data          (d_in[g]),
         .i_shift_amt     (amt[g]),
         .i_shift_left    (left[g]),
         .i_signed        (sgn[g]),
         .o_sh_data       (sh_d_o[g]),
         .o_sh_shift_amt  (sh_amt[g]),
         .o_sh_shift_left (sh_left[g]),
         .o_sh_signed     (sh_sgn[g]),
         .i_sh_data       (sh_d_i[g]),
         .o_valid         (vo[g]),
         .i_ready         (rdy_in[g]),
         .o_data          (d_out[g])
      );
      // Behavioural barrel shifter with g cycles of output latency.
      assign comb_v = golden(sh_d_o[g], {3'b000, sh_amt[g]}, sh_left[g], sh_sgn[g]);
      always @(posedge clk) begin
         p1 <= comb_v;
         p2 <= p1;
         p3 <= p2;
      end
      assign sh_d_i[g] = (g == 0) ? comb_v : (g == 1) ? p1 : (g == 2) ? p2 : p3;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input int idx, input logic [31:0] data, input logic [7:0] n,
                        input logic l, input logic s);
      int guard = 0;
      sb_data.push_back(golden(data, n, l, s));
      sb_lat.push_back(((n >= 8'd32) ? 2 : 1) * (idx + 1));
      d_in[idx] = data;
      amt[idx]  = n;
      left[idx] = l;
      sgn[idx]  = s;
      v_in[idx] = 1'b1;
      while (!rdy_out[idx] && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("accept_wait", 32'(guard < 20), 32'd1);
      @(posedge clk); #1;
      v_in[idx] = 1'b0;
      first_amt = sh_amt[idx];
      last_amt  = first_amt;
   endtask

   task automatic wait_done(input int idx, output int c);
      c = 0;
      while (!vo[idx] && c < 50) begin
         last_amt = sh_amt[idx];
         @(posedge clk); #1;
         c++;
      end
      chk("done_timeout", 32'(vo[idx]), 32'd1);
   endtask

   task automatic finish_cmd(input int idx, input int c, input string tag);
      logic [31:0] e;
      int el;
      e  = (sb_data.size() > 0) ? sb_data.pop_front() : 32'hxxxx_xxxx;
      el = (sb_lat.size() > 0) ? sb_lat.pop_front() : -1;
      chk({tag, "_data"}, d_out[idx], e);
      chk({tag, "_latency"}, 32'(c), 32'(el));
      @(posedge clk); #1;
      chk({tag, "_valid_drop"}, 32'(vo[idx]), 32'd0);
      chk({tag, "_ready_back"}, 32'(rdy_out[idx]), 32'd1);
   endtask

   initial begin
      v_in = '0; rdy_in = '1; left = '0; sgn = '0;
      for (int i = 0; i < 4; i++) begin
         d_in[i] = '0;
         amt[i]  = '0;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(rdy_out[1]), 32'd0);
      chk("rst_valid", 32'(vo[1]), 32'd0);
      chk("rst_data", d_out[1], 32'h0);
      chk("rst_sh_data", sh_d_o[1], 32'h0);
      chk("rst_sh_amt", 32'(sh_amt[1]), 32'd0);
      chk("rst_sh_flags", {30'd0, sh_left[1], sh_sgn[1]}, 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", 32'(rdy_out[1]), 32'd1);

      // Left shift by 4, one pass.
      issue(1, 32'h0000_0001, 8'd4, 1'b1, 1'b0);
      chk("l4_pass_amt", 32'(first_amt), 32'd4);
      wait_done(1, cyc);
      finish_cmd(1, cyc, "l4");

      // Arithmetic right by 40: passes of 31 then 1.
      issue(1, 32'h8000_0000, 8'd40, 1'b0, 1'b1);
      chk("ar40_pass1_amt", 32'(first_amt), 32'd31);
      wait_done(1, cyc);
      chk("ar40_pass2_amt", 32'(last_amt), 32'd1);
      finish_cmd(1, cyc, "ar40");

      issue(1, 32'h8000_0000, 8'd40, 1'b0, 1'b0);
      wait_done(1, cyc);
      finish_cmd(1, cyc, "lr40");

      issue(1, 32'hDEAD_BEEF, 8'd0, 1'b0, 1'b0);
      chk("amt0_pass_amt", 32'(first_amt), 32'd0);
      wait_done(1, cyc);
      finish_cmd(1, cyc, "amt0");

      issue(1, 32'hFFFF_FFFF, 8'd255, 1'b1, 1'b0);
      wait_done(1, cyc);
      finish_cmd(1, cyc, "l255");

      // Backpressure with a second command held valid throughout DONE.
      rdy_in[1] = 1'b0;
      issue(1, 32'h1234_5678, 8'd8, 1'b1, 1'b0);
      wait_done(1, cyc);
      hold_exp = sb_data.pop_front();
      chk("bp_data", d_out[1], hold_exp);
      chk("bp_latency", 32'(cyc), 32'(sb_lat.pop_front()));
      d_in[1] = 32'h0000_00F0; amt[1] = 8'd4; left[1] = 1'b0; sgn[1] = 1'b0;
      v_in[1] = 1'b1;
      sb_data.push_back(32'h0000_000F);
      sb_lat.push_back(2);
      repeat (3) begin
         @(posedge clk); #1;
         chk("bp_hold_valid", 32'(vo[1]), 32'd1);
         chk("bp_hold_data", d_out[1], hold_exp);
         chk("bp_hold_ready", 32'(rdy_out[1]), 32'd0);
      end
      rdy_in[1] = 1'b1;
      @(posedge clk); #1;
      chk("bp_valid_drop", 32'(vo[1]), 32'd0);
      chk("bp_ready_back", 32'(rdy_out[1]), 32'd1);
      @(posedge clk); #1;
      v_in[1] = 1'b0;
      wait_done(1, cyc);
      finish_cmd(1, cyc, "bp_second");

      // Reset during pass 1 of a 2-pass command.
      issue(1, 32'h8000_0000, 8'd40, 1'b0, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_valid", 32'(vo[1]), 32'd0);
      chk("midrst_data", d_out[1], 32'h0);
      chk("midrst_sh_amt", 32'(sh_amt[1]), 32'd0);
      rst = 1'b0;
      #1;
      chk("midrst_ready", 32'(rdy_out[1]), 32'd1);
      void'(sb_data.pop_back());
      void'(sb_lat.pop_back());
      quiet = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
         if (vo[1]) quiet = 1'b0;
      end
      chk("midrst_no_valid", 32'(quiet), 32'd1);
      issue(1, 32'h0000_0003, 8'd33, 1'b1, 1'b0);
      wait_done(1, cyc);
      finish_cmd(1, cyc, "after_rst");

      // Random sweep across all latencies.
      for (int g = 0; g < 4; g++) begin
         for (int k = 0; k < 8; k++) begin
            logic [7:0] n;
            if (k == 0) n = 8'd31;
            else if (k == 1) n = 8'd32;
            else if (k % 2 == 1) n = 8'($urandom_range(0, 255));
            else n = 8'($urandom_range(0, 40));
            issue(g, 32'($urandom), n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_done(g, cyc);
            finish_cmd(g, cyc, "sweep");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
